// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types for the USB low/full-speed transmit path.
//   d_port_t   : line state driven to the transceiver ({D+, D-} levels).
//   tx_state_t : transmit FSM states.
//   SYNC_BYTE  : SYNC pattern, sent LSB first through the NRZI/stuff path.
package usb_tx_pkg;

    // Full-speed polarity: J = D+ high, K = D- high, SE0 = both low.
    typedef enum logic [1:0] {
        SE0 = 2'b00,
        K   = 2'b01,
        J   = 2'b10
    } d_port_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SYNC    = 3'd1,
        TX_DATA    = 3'd2,
        TX_EOP_SE0 = 3'd3,
        TX_EOP_J   = 3'd4
    } tx_state_t;

    // NRZI: a 0 bit flips the line between J and K.
    function automatic d_port_t nrzi_toggle(d_port_t lvl);
        return (lvl == J) ? K : J;
    endfunction

endpackage

// File: rtl/usb_tx_bitenc.sv
// usb_tx_bitenc: NRZI encoder with bit stuffing and registered line output.
//   clk, reset     : system clock, synchronous active-low reset.
//   bit_i          : data bit to send on this strobe.
//   bit_strobe_i   : send one bit time (a stuffed 0 instead of bit_i while stall_o).
//   force_se0_i    : drive SE0 for this bit time; clears level and ones count.
//   force_j_i      : drive J for this bit time; clears level and ones count.
//   line_o         : registered line state.
//   stall_o        : the next strobe sends a stuffed bit; bit_i is not consumed.
module usb_tx_bitenc
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT = 6
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    bit_i,
    input  logic    bit_strobe_i,
    input  logic    force_se0_i,
    input  logic    force_j_i,
    output d_port_t line_o,
    output logic    stall_o
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);

    logic [OW-1:0] ones_q, ones_d;
    d_port_t       lvl_q, lvl_d;
    d_port_t       line_q, line_d;

    assign stall_o = (ones_q == OW'(STUFF_LIMIT));
    assign line_o  = line_q;

    always_comb begin
        ones_d = ones_q;
        lvl_d  = lvl_q;
        line_d = line_q;
        if (force_se0_i) begin
            // EOP: level returns to J so the next packet's SYNC starts from idle.
            line_d = SE0;
            lvl_d  = J;
            ones_d = '0;
        end else if (force_j_i) begin
            line_d = J;
            lvl_d  = J;
            ones_d = '0;
        end else if (bit_strobe_i) begin
            if (stall_o || !bit_i) begin
                lvl_d  = nrzi_toggle(lvl_q);
                line_d = nrzi_toggle(lvl_q);
                ones_d = '0;
            end else begin
                line_d = lvl_q;
                ones_d = ones_q + OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ones_q <= '0;
            lvl_q  <= J;
            line_q <= J;
        end else begin
            ones_q <= ones_d;
            lvl_q  <= lvl_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/usb_tx.sv
// usb_tx: USB low/full-speed transmitter (SYNC, NRZI + bit-stuffed data, EOP).
//   clk      : 24 MHz system clock.
//   reset    : synchronous active-low reset.
//   clk_en   : one pulse per bit time; all state advances only on these edges.
//   tx_data  : byte from the SIE, sent LSB first.
//   tx_valid : SIE has a byte; low at a byte boundary ends the packet.
//   tx_ready : one-clk pulse after the edge that consumed tx_data.
//   d_o      : registered line state (J/K/SE0).
//   oe       : registered driver enable.
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output d_port_t    d_o,
    output logic       oe
);

    localparam int EW = $clog2(EOP_SE0_BITS + 1);

    tx_state_t     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;      // SYNC bit index / DATA bit index (0 = boundary)
    logic [6:0]    sh_q, sh_d;        // bits 7:1 of the byte being sent
    logic [EW-1:0] eop_q, eop_d;      // SE0 bit times already sent
    logic          oe_q, oe_d;
    logic          rdy_q, rdy_d;

    logic enc_bit, enc_strobe, enc_se0, enc_j, stall;

    usb_tx_bitenc #(
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_bitenc (
        .clk          (clk),
        .reset        (reset),
        .bit_i        (enc_bit),
        .bit_strobe_i (enc_strobe),
        .force_se0_i  (enc_se0),
        .force_j_i    (enc_j),
        .line_o       (d_o),
        .stall_o      (stall)
    );

    assign oe       = oe_q;
    assign tx_ready = rdy_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        eop_d      = eop_q;
        oe_d       = oe_q;
        rdy_d      = 1'b0;
        enc_bit    = 1'b0;
        enc_strobe = 1'b0;
        enc_se0    = 1'b0;
        enc_j      = 1'b0;
        if (clk_en) begin
            unique case (state_q)
                TX_IDLE: begin
                    if (tx_valid) begin
                        // First SYNC bit goes out on the same edge that sees tx_valid.
                        enc_strobe = 1'b1;
                        enc_bit    = SYNC_BYTE[0];
                        oe_d       = 1'b1;
                        cnt_d      = 3'd1;
                        state_d    = TX_SYNC;
                    end else begin
                        enc_j = 1'b1;
                        oe_d  = 1'b0;
                    end
                end
                TX_SYNC: begin
                    enc_strobe = 1'b1;
                    enc_bit    = SYNC_BYTE[cnt_q];
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (stall) begin
                        // Stuffed bit owed: send it, hold the data bit (and any
                        // boundary decision) until the next edge.
                        enc_strobe = 1'b1;
                    end else if (cnt_q == 3'd0) begin
                        if (tx_valid) begin
                            enc_strobe = 1'b1;
                            enc_bit    = tx_data[0];
                            sh_d       = tx_data[7:1];
                            rdy_d      = 1'b1;
                            cnt_d      = 3'd1;
                        end else begin
                            enc_se0 = 1'b1;
                            eop_d   = EW'(1);
                            state_d = TX_EOP_SE0;
                        end
                    end else begin
                        enc_strobe = 1'b1;
                        enc_bit    = sh_q[0];
                        sh_d       = {1'b0, sh_q[6:1]};
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
                TX_EOP_SE0: begin
                    if (eop_q < EW'(EOP_SE0_BITS)) begin
                        enc_se0 = 1'b1;
                        eop_d   = eop_q + EW'(1);
                    end else begin
                        enc_j   = 1'b1;
                        state_d = TX_EOP_J;
                    end
                end
                TX_EOP_J: begin
                    // tx_valid is deliberately ignored here: guarantees one idle bit.
                    enc_j   = 1'b1;
                    oe_d    = 1'b0;
                    state_d = TX_IDLE;
                end
                default: begin
                    enc_j   = 1'b1;
                    oe_d    = 1'b0;
                    state_d = TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= 3'd0;
            sh_q    <= 7'd0;
            eop_q   <= '0;
            oe_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            eop_q   <= eop_d;
            oe_q    <= oe_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: scoreboard bench for usb_tx. Each test pushes SIE bytes and the
// hand-derived per-bit-time line sequence; a monitor pops one expectation per
// clk_en (or reset) edge and checks d_o/oe/tx_ready, and checks that outputs
// hold on non-enable clocks.
// Sequence chars: J/K = line with oe=1, j/k = same plus tx_ready expected,
// 0 = SE0 with oe=1, i = idle J with oe=0.
module tb_usb_tx;
    import usb_tx_pkg::*;

    typedef struct {
        d_port_t d;
        logic    oe;
        logic    rdy;
        int      tid;
        int      idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    d_port_t    d_o;
    logic       oe;

    int checks = 0;
    int failures = 0;

    exp_t       sq[$];
    logic [8:0] bq[$];      // {last_of_packet, byte}
    logic       gap = 1'b0;
    int         en_div = 1;
    int         phase = 0;

    usb_tx #(.STUFF_LIMIT(6), .EOP_SE0_BITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .d_o      (d_o),
        .oe       (oe)
    );

    initial forever #5 clk = ~clk;

    function automatic string ls(d_port_t v);
        case (v)
            J:       return "J";
            K:       return "K";
            SE0:     return "SE0";
            default: return "X";
        endcase
    endfunction

    // ---------------- monitor ----------------
    exp_t    me;
    logic    en_s, rs_s;
    d_port_t last_d = J;
    logic    last_oe = 1'b0;

    always @(posedge clk) begin
        en_s = clk_en;
        rs_s = reset;
        #1;
        if (en_s === 1'b1 || rs_s === 1'b0) begin
            checks++;
            if (sq.size() > 0) begin
                me = sq.pop_front();
                if (d_o !== me.d || oe !== me.oe || tx_ready !== me.rdy) begin
                    failures++;
                    $display("FAIL seq t%0d.%0d: got d_o=%s oe=%b rdy=%b, expected d_o=%s oe=%b rdy=%b",
                             me.tid, me.idx, ls(d_o), oe, tx_ready, ls(me.d), me.oe, me.rdy);
                end
            end else if (d_o !== J || oe !== 1'b0 || tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL idle: got d_o=%s oe=%b rdy=%b, expected d_o=J oe=0 rdy=0",
                         ls(d_o), oe, tx_ready);
            end
            last_d  = d_o;
            last_oe = oe;
        end else begin
            checks++;
            if (d_o !== last_d || oe !== last_oe || tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold: got d_o=%s oe=%b rdy=%b, expected d_o=%s oe=%b rdy=0",
                         ls(d_o), oe, tx_ready, ls(last_d), last_oe);
            end
        end
    end

    // ---------------- SIE model / stimulus ----------------
    task automatic drive();
        logic [8:0] hd;
        if (bq.size() > 0) begin
            hd       = bq[0];
            tx_valid = !gap;
            tx_data  = hd[7:0];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
        end
    endtask

    // Called once per negedge.
    task automatic step();
        logic [8:0] hd;
        if (tx_ready === 1'b1 && bq.size() > 0) begin
            hd = bq.pop_front();
            if (hd[8]) gap = 1'b1;
        end
        // Present the next packet during EOP to show it is held off until IDLE.
        if (gap && d_o == SE0) gap = 1'b0;
        phase  = (phase + 1) % en_div;
        clk_en = (phase == 0);
        drive();
    endtask

    task automatic push_seq(input string s, input int tid);
        exp_t e;
        byte  c;
        for (int i = 0; i < s.len(); i++) begin
            c     = s[i];
            e.tid = tid;
            e.idx = i;
            e.oe  = 1'b1;
            e.rdy = 1'b0;
            e.d   = J;
            case (c)
                "J": e.d = J;
                "K": e.d = K;
                "j": begin e.d = J; e.rdy = 1'b1; end
                "k": begin e.d = K; e.rdy = 1'b1; end
                "0": e.d = SE0;
                default: e.oe = 1'b0;   // 'i'
            endcase
            sq.push_back(e);
        end
    endtask

    task automatic run_until(input int remaining, input int tid);
        int n;
        n = 0;
        while (sq.size() > remaining && n < 4000) begin
            @(negedge clk);
            step();
            n++;
        end
        checks++;
        if (sq.size() > remaining) begin
            failures++;
            $display("FAIL timeout t%0d: %0d bit times outstanding, expected %0d",
                     tid, sq.size(), remaining);
            sq.delete();
            bq.delete();
            gap = 1'b0;
            drive();
        end
    endtask

    task automatic set_div(input int d);
        en_div = d;
        phase  = 0;
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            step();
        end
        checks += 3;
        if (d_o !== J)         begin failures++; $display("FAIL reset_d: got %s, expected J", ls(d_o)); end
        if (oe !== 1'b0)       begin failures++; $display("FAIL reset_oe: got %b, expected 0", oe); end
        if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b, expected 0", tx_ready); end
        reset = 1'b1;

        // t1: 0x00, clk_en every clk
        set_div(1);
        bq.push_back({1'b1, 8'h00});
        push_seq("KJKJKJKKjKJKJKJK00Ji", 1);
        drive();
        run_until(0, 1);

        // t2: 0xFF, stuff after 5 data ones (SYNC's last 1 counts)
        bq.push_back({1'b1, 8'hFF});
        push_seq("KJKJKJKKkKKKKJJJJ00Ji", 2);
        drive();
        run_until(0, 2);

        // t3: 0xFC, stuff owed at end goes out before SE0
        bq.push_back({1'b1, 8'hFC});
        push_seq("KJKJKJKKjKKKKKKKJ00Ji", 3);
        drive();
        run_until(0, 3);

        // t4: 0xFC,0x01, stuff at a byte boundary delays the load by one bit
        bq.push_back({1'b0, 8'hFC});
        bq.push_back({1'b1, 8'h01});
        push_seq("KJKJKJKKjKKKKKKKJjKJKJKJK00Ji", 4);
        drive();
        run_until(0, 4);

        // t5: 0x2D,0xA5 then packet 0x01 queued during EOP; clk_en every 2nd clk
        set_div(2);
        bq.push_back({1'b0, 8'h2D});
        bq.push_back({1'b1, 8'hA5});
        bq.push_back({1'b1, 8'h01});
        push_seq("KJKJKJKKkJJJKKJKkJJKJJKK00Ji", 5);
        push_seq("KJKJKJKKkJKJKJKJ00Ji", 6);
        drive();
        run_until(0, 5);

        // t7: 0xFF,0xFF, ones count carries across the byte boundary; clk_en every 3rd
        set_div(3);
        bq.push_back({1'b0, 8'hFF});
        bq.push_back({1'b1, 8'hFF});
        push_seq("KJKJKJKKkKKKKJJJJjJJKKKKKK00Ji", 7);
        drive();
        run_until(0, 7);

        // t8: reset at data bit 4 with tx_valid still high, then fresh SYNC
        set_div(1);
        bq.push_back({1'b0, 8'h00});
        bq.push_back({1'b1, 8'h55});
        push_seq("KJKJKJKKjKJK", 8);
        push_seq("i", 9);
        push_seq("KJKJKJKKkJJKKJJK00Ji", 10);
        drive();
        run_until(21, 8);
        reset = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b1;
        run_until(0, 10);

        repeat (5) begin
            @(negedge clk);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_tx.md
Name: usb_tx

Overview:
USB low/full speed transmitter: the transmit-side counterpart of the existing USB receive path.
- Accepts bytes from the SIE over a valid/ready handshake.
- Emits SYNC, NRZI-encoded, bit-stuffed data, then EOP as line states (d_port_t) to the transceiver, with an output-enable.
- Runs on the 24 MHz system clock; a one-cycle-per-bit clk_en sets the bit rate (12 Mb/s or 1.5 Mb/s).

Parameters:
- STUFF_LIMIT, 6, consecutive transmitted 1-bits after which a stuffed 0 is inserted.
- EOP_SE0_BITS, 2, number of SE0 bit times in EOP.

Ports:
- clk  input  1  system clock (24 MHz).
- reset  input  1  synchronous, active-low reset (asserted when 0).
- clk_en  input  1  bit-time enable; all state advances only when 1.
- tx_data  input  8  byte to send, LSB first.
- tx_valid  input  1  SIE has a byte; low at a byte boundary ends the packet.
- tx_ready  output  1  one-clk pulse: tx_data has been consumed.
- d_o  output  d_port_t  line state to transceiver (J/K/SE0).
- oe  output  1  driver enable.

Behaviour:
- Reset (reset==0, sampled on clk, independent of clk_en): state IDLE, d_o=J, oe=0, tx_ready=0, ones counter=0, NRZI level=J. Reset mid-packet aborts immediately with no EOP.
- d_o and oe are registered and change only on clk_en edges. tx_ready is registered: high for exactly one clk following the clk_en edge that loaded a byte.
- IDLE: d_o=J, oe=0. On a clk_en edge with tx_valid=1, go to SYNC. Latency: d_o=K, oe=1 after that same edge.
- SYNC: 8 bit times sending 8'h80 LSB first through the NRZI/stuff path; the line shows K J K J K J K K.
- Bit stuffing starts with SYNC. After SYNC the ones counter is 1.
- NRZI: a 0 toggles J<->K; a 1 holds the level.
- Stuffing: when the ones counter reaches STUFF_LIMIT, the next bit time sends a stuffed 0 (toggle), the counter clears, and the data bit is held back one bit time. Any 0 clears the counter. The counter persists across byte boundaries.
- Byte boundary: this is the clk_en edge that would send bit 0 of the next byte. A pending stuff bit is sent first, and the boundary decision moves to the following edge.
  - tx_valid=1: drive tx_data[0], latch tx_data[7:1] into the shift register, pulse tx_ready.
  - tx_valid=0: go to EOP.
- tx_valid and tx_data are sampled only at boundaries. The SIE must present the next byte, or drop tx_valid, within 7 bit times after tx_ready.
- EOP: drive SE0 for EOP_SE0_BITS bit times, then J for 1 bit time with oe=1, then IDLE (oe=0 on the next clk_en edge).
- tx_valid=1 in the last EOP J bit time is ignored. It is sampled in IDLE on the next clk_en edge, so the minimum inter-packet gap is 1 idle bit time.
- A stuff bit owed after the last data bit is sent before the first SE0.
- States: IDLE, SYNC (3-bit counter), DATA (3-bit bit counter), EOP_SE0 (counter), EOP_J.

Decomposition:
- types package (existing): d_port_t with J/K/SE0.
- Add to types: SYNC_BYTE=8'h80, and a tx_state_t enum with explicit state encodings (same style as the RX FSM).
- One natural sub-module, usb_tx_bitenc:
  - Contains the ones counter, stuff insertion and NRZI level register.
  - Inputs: bit, bit_strobe, force_se0, force_j.
  - Outputs: line state, stall (stuff in progress).
  - The top holds the FSM and shift register.

Test Plan:
- 1 byte 0x00, clk_en every cycle -> d_o: K J K J K J K K, then J K J K J K J K, then SE0 SE0 J, then oe=0; one tx_ready pulse.
- 1 byte 0xFF -> after SYNC: K K K K K (count hits 6 including SYNC bit), stuffed J, J J J, then SE0 SE0 J; data phase is 9 bit times.
- 1 byte 0xFC -> after SYNC: J K, K x6, stuffed J, then SE0 SE0 J (stuff before EOP).
- 2 bytes 0x2D, 0xA5 back-to-back, clk_en every 2nd clk -> 16 data bit times with no gap; tx_ready pulses twice, each 1 clk wide; d_o is stable on non-enable clks; the second packet starts only after 1 idle J.
- reset driven low at data bit 4 -> next clk: d_o=J, oe=0, tx_ready=0. With tx_valid held and reset=1, a fresh SYNC starts on the next clk_en edge.
